// File: rtl/canvas_uart_dump_if.sv
// canvas_uart_dump_if: bundles the dump request/status handshake, the tile
// RAM read port and the UART line of canvas_uart_dump.
//   start    : one-cycle dump request (host -> dumper)
//   busy     : dump in progress (dumper -> host)
//   done     : one-cycle pulse when the dump has completed (dumper -> host)
//   ram_addr : tile RAM read address {row[4:0], col[6:0]} (dumper -> RAM)
//   ram_dout : tile RAM read data, one cycle after ram_addr (RAM -> dumper)
//   tx       : UART 8N1 serial output, idles high (dumper -> line)
interface canvas_uart_dump_if;
  logic        start;
  logic        busy;
  logic        done;
  logic [11:0] ram_addr;
  logic [6:0]  ram_dout;
  logic        tx;

  modport master (output start, ram_dout, input busy, done, ram_addr, tx);
  modport slave  (input start, ram_dout, output busy, done, ram_addr, tx);
endinterface

// File: rtl/canvas_uart_dump.sv
// canvas_uart_dump: on request, walks the (MAX_X+1)x(MAX_Y+1) tile RAM through
// its read port and sends it as ASCII over UART (8N1, LSB first): DOT_CHAR
// for a nonzero tile, BLANK_CHAR for a zero tile, CR LF after every row.
//   clk_100MHz : system clock
//   reset      : synchronous, active-high reset
//   bus        : canvas_uart_dump_if.slave (start/busy/done, RAM read, tx)
module canvas_uart_dump #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned MAX_X        = 79,
  parameter int unsigned MAX_Y        = 29,
  parameter logic [7:0]  DOT_CHAR     = 8'h23,
  parameter logic [7:0]  BLANK_CHAR   = 8'h2E
) (
  input  logic               clk_100MHz,
  input  logic               reset,
  canvas_uart_dump_if.slave  bus
);

  localparam logic [11:0] BAUD_LAST = 12'(CLKS_PER_BIT - 1);
  localparam logic [6:0]  COL_LAST  = 7'(MAX_X);
  localparam logic [4:0]  ROW_LAST  = 5'(MAX_Y);
  localparam logic [7:0]  CR_CHAR   = 8'h0D;
  localparam logic [7:0]  LF_CHAR   = 8'h0A;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_LATCH, S_SEND, S_ADV, S_DONE
  } state_t;

  // What the character currently in flight was, so ADV knows what follows.
  typedef enum logic [1:0] {K_TILE, K_CR, K_LF} kind_t;

  state_t      state_q, state_d;
  kind_t       kind_q, kind_d;
  logic [4:0]  row_q, row_d;
  logic [6:0]  col_q, col_d;
  logic [7:0]  char_q, char_d;
  logic [3:0]  bit_q, bit_d;
  logic [11:0] baud_q, baud_d;
  logic [11:0] addr_q, addr_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [9:0]  frame;

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    row_d   = row_q;
    col_d   = col_q;
    char_d  = char_q;
    bit_d   = bit_q;
    baud_d  = baud_q;
    addr_d  = addr_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          row_d   = '0;
          col_d   = '0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: state_d = S_LATCH;
      S_LATCH: begin
        char_d  = (bus.ram_dout != '0) ? DOT_CHAR : BLANK_CHAR;
        kind_d  = K_TILE;
        bit_d   = '0;
        baud_d  = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == 4'd9) state_d = S_ADV;
          else               bit_d   = bit_q + 4'd1;
        end else begin
          baud_d = baud_q + 12'd1;
        end
      end
      S_ADV: begin
        bit_d  = '0;
        baud_d = '0;
        case (kind_q)
          K_TILE: begin
            if (col_q < COL_LAST) begin
              col_d   = col_q + 7'd1;
              state_d = S_ADDR;
            end else begin
              char_d  = CR_CHAR;
              kind_d  = K_CR;
              state_d = S_SEND;
            end
          end
          K_CR: begin
            char_d  = LF_CHAR;
            kind_d  = K_LF;
            state_d = S_SEND;
          end
          default: begin
            if (row_q < ROW_LAST) begin
              row_d   = row_q + 5'd1;
              col_d   = '0;
              state_d = S_ADDR;
            end else begin
              state_d = S_DONE;
            end
          end
        endcase
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next-state values so that they line up
    // with the state they describe instead of lagging it by one cycle.
    if (state_d == S_ADDR) addr_d = {row_d, col_d};
    frame  = {1'b1, char_d, 1'b0};
    tx_d   = (state_d == S_SEND) ? frame[bit_d] : 1'b1;
    busy_d = (state_d == S_ADDR) || (state_d == S_LATCH) ||
             (state_d == S_SEND) || (state_d == S_ADV);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q <= S_IDLE;
      kind_q  <= K_TILE;
      row_q   <= '0;
      col_q   <= '0;
      char_q  <= '0;
      bit_q   <= '0;
      baud_q  <= '0;
      addr_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      row_q   <= row_d;
      col_q   <= col_d;
      char_q  <= char_d;
      bit_q   <= bit_d;
      baud_q  <= baud_d;
      addr_q  <= addr_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.ram_addr = addr_q;
  assign bus.tx       = tx_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_canvas_uart_dump.sv
// Bench for canvas_uart_dump: a small canvas instance (4x2 tiles, 4 clocks/bit)
// and a full-size canvas instance (80x30 tiles, 2 clocks/bit), each with its
// own synchronous-read tile RAM. The tx line is recorded cycle by cycle and
// decoded as UART text, then compared with text built from the RAM contents.
module tb_canvas_uart_dump;
  logic clk_100MHz = 1'b0;
  logic reset;
  always #5 clk_100MHz = ~clk_100MHz;

  canvas_uart_dump_if ia();
  canvas_uart_dump_if ib();

  canvas_uart_dump #(.CLKS_PER_BIT(4), .MAX_X(3), .MAX_Y(1)) dut_a (
    .clk_100MHz(clk_100MHz), .reset(reset), .bus(ia.slave));
  canvas_uart_dump #(.CLKS_PER_BIT(2), .MAX_X(79), .MAX_Y(29)) dut_b (
    .clk_100MHz(clk_100MHz), .reset(reset), .bus(ib.slave));

  logic [6:0] mem_a [4096];
  logic [6:0] mem_b [4096];
  always @(posedge clk_100MHz) begin
    ia.ram_dout <= mem_a[ia.ram_addr];
    ib.ram_dout <= mem_b[ib.ram_addr];
  end

  int total = 0;
  int bad   = 0;
  int sel   = 0;
  bit tr_tx[$];
  bit tr_busy[$];
  bit tr_done[$];
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int gaps[$];
  int first_start;
  int bit_errs;

  function automatic int nb();  return (sel != 0) ? 2  : 4; endfunction
  function automatic int mxf(); return (sel != 0) ? 79 : 3; endfunction
  function automatic int myf(); return (sel != 0) ? 29 : 1; endfunction

  // Cycle index of the done pulse, counting the cycle start is accepted as 0.
  function automatic int done_idx();
    int n = nb();
    return 1 + (myf() + 1) * ((mxf() + 1) * (10 * n + 3) + 2 * (10 * n + 1));
  endfunction

  task automatic set_start(input logic v);
    if (sel != 0) ib.start = v; else ia.start = v;
  endtask

  task automatic build_expected();
    exp_q.delete();
    for (int y = 0; y <= myf(); y++) begin
      for (int x = 0; x <= mxf(); x++) begin
        logic [6:0] v = (sel != 0) ? mem_b[y * 128 + x] : mem_a[y * 128 + x];
        exp_q.push_back((v != 7'h0) ? 8'h23 : 8'h2E);
      end
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endtask

  task automatic capture(input bit extra);
    int d = done_idx();
    tr_tx.delete(); tr_busy.delete(); tr_done.delete();
    for (int k = 0; k < d + 20; k++) begin
      @(negedge clk_100MHz);
      set_start(k == 0 || (extra && (k == 50 || k == d)));
      tr_tx.push_back((sel != 0) ? ib.tx : ia.tx);
      tr_busy.push_back((sel != 0) ? ib.busy : ia.busy);
      tr_done.push_back((sel != 0) ? ib.done : ia.done);
    end
    set_start(1'b0);
  endtask

  task automatic decode();
    int n = nb();
    int i = 0;
    int last_end = -1;
    got.delete(); gaps.delete();
    first_start = -1;
    bit_errs = 0;
    while (i < tr_tx.size()) begin
      if (tr_tx[i] == 1'b0) begin
        logic [7:0] ch;
        ch = '0;
        if (first_start < 0) first_start = i;
        if (i + 10 * n > tr_tx.size()) begin
          bit_errs++;
          break;
        end
        for (int b = 0; b < 10; b++) begin
          bit lvl;
          lvl = tr_tx[i + b * n];
          for (int c = 1; c < n; c++)
            if (tr_tx[i + b * n + c] != lvl) bit_errs++;
          if (b == 9 && lvl != 1'b1) bit_errs++;
          if (b >= 1 && b <= 8) ch[b - 1] = lvl;
        end
        got.push_back(ch);
        if (last_end >= 0) gaps.push_back(i - last_end);
        last_end = i + 10 * n;
        i = last_end;
      end else begin
        i++;
      end
    end
  endtask

  task automatic check_dump(input string name);
    int d = done_idx();
    int mism = 0;
    int gap_bad = 0;
    int dcount = 0;
    int busy_bad = 0;
    build_expected();
    decode();
    total++;
    if (got.size() != exp_q.size()) begin
      bad++;
      $display("FAIL %s char_count got=%0d exp=%0d", name, got.size(), exp_q.size());
    end
    for (int j = 0; j < got.size() && j < exp_q.size(); j++)
      if (got[j] !== exp_q[j]) mism++;
    total++;
    if (mism != 0) begin
      bad++;
      $display("FAIL %s char_content mismatching_chars=%0d exp=0", name, mism);
    end
    total++;
    if (bit_errs != 0) begin
      bad++;
      $display("FAIL %s bit_timing errors=%0d exp=0", name, bit_errs);
    end
    for (int j = 0; j < gaps.size(); j++) begin
      if (j + 1 < exp_q.size()) begin
        int eg;
        eg = (exp_q[j + 1] == 8'h0D || exp_q[j + 1] == 8'h0A) ? 1 : 3;
        if (gaps[j] != eg) gap_bad++;
      end
    end
    total++;
    if (gap_bad != 0) begin
      bad++;
      $display("FAIL %s frame_gaps wrong_gaps=%0d exp=0", name, gap_bad);
    end
    total++;
    if (first_start != 3) begin
      bad++;
      $display("FAIL %s first_start_bit got=%0d exp=3", name, first_start);
    end
    for (int k = 0; k < tr_done.size(); k++) if (tr_done[k]) dcount++;
    total++;
    if (dcount != 1) begin
      bad++;
      $display("FAIL %s done_pulses got=%0d exp=1", name, dcount);
    end
    total++;
    if (tr_done[d] !== 1'b1) begin
      bad++;
      $display("FAIL %s done_cycle got=%0b exp=1 at cycle %0d", name, tr_done[d], d);
    end
    for (int k = 0; k < tr_busy.size(); k++)
      if (tr_busy[k] != (k >= 1 && k < d)) busy_bad++;
    total++;
    if (busy_bad != 0) begin
      bad++;
      $display("FAIL %s busy_window wrong_cycles=%0d exp=0", name, busy_bad);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk_100MHz);
    total++;
    if ({ia.tx, ia.busy, ia.done} !== 3'b100 || ia.ram_addr !== 12'h0) begin
      bad++;
      $display("FAIL reset_a got tx/busy/done=%b%b%b addr=%h exp=100 addr=000",
               ia.tx, ia.busy, ia.done, ia.ram_addr);
    end
    total++;
    if ({ib.tx, ib.busy, ib.done} !== 3'b100 || ib.ram_addr !== 12'h0) begin
      bad++;
      $display("FAIL reset_b got tx/busy/done=%b%b%b addr=%h exp=100 addr=000",
               ib.tx, ib.busy, ib.done, ib.ram_addr);
    end
    reset = 1'b0;
    @(negedge clk_100MHz);
  endtask

  task automatic test_blank();
    sel = 0;
    for (int i = 0; i < 4096; i++) mem_a[i] = 7'h0;
    capture(1'b0);
    check_dump("blank");
  endtask

  task automatic test_pattern();
    sel = 0;
    for (int i = 0; i < 4096; i++) mem_a[i] = 7'h0;
    mem_a[2]   = 7'h01;
    mem_a[128] = 7'h7F;
    capture(1'b0);
    check_dump("pattern");
  endtask

  task automatic test_ignored_start();
    sel = 0;
    for (int i = 0; i < 4096; i++)
      mem_a[i] = ($urandom_range(0, 1) != 0) ? 7'($urandom) : 7'h0;
    capture(1'b1);
    check_dump("ignored_start");
  endtask

  task automatic test_reset_mid();
    int idle_bad = 0;
    sel = 0;
    for (int i = 0; i < 4096; i++) mem_a[i] = 7'h0;
    mem_a[1] = 7'h05;   // second character '#': data bit 3 is 0 on the line
    for (int k = 0; k <= 64; k++) begin
      @(negedge clk_100MHz);
      set_start(k == 0);
      if (k == 63) begin
        total++;
        if (ia.tx !== 1'b0 || ia.busy !== 1'b1) begin
          bad++;
          $display("FAIL pre_reset got tx=%b busy=%b exp tx=0 busy=1", ia.tx, ia.busy);
        end
        reset = 1'b1;
      end
      if (k == 64) begin
        total++;
        if (ia.tx !== 1'b1 || ia.busy !== 1'b0 || ia.done !== 1'b0) begin
          bad++;
          $display("FAIL mid_reset got tx=%b busy=%b done=%b exp 1 0 0",
                   ia.tx, ia.busy, ia.done);
        end
        reset = 1'b0;
      end
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_100MHz);
      if (ia.tx !== 1'b1 || ia.busy !== 1'b0 || ia.done !== 1'b0) idle_bad++;
    end
    total++;
    if (idle_bad != 0) begin
      bad++;
      $display("FAIL post_reset_idle wrong_cycles=%0d exp=0", idle_bad);
    end
    mem_a[129] = 7'h40;
    capture(1'b0);
    check_dump("after_reset");
  endtask

  task automatic test_full_canvas();
    sel = 1;
    for (int i = 0; i < 4096; i++)
      mem_b[i] = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'h0;
    capture(1'b0);
    check_dump("full_canvas");
    total++;
    if (got.size() != 2460) begin
      bad++;
      $display("FAIL full_char_total got=%0d exp=2460", got.size());
    end
    sel = 0;
  endtask

  initial begin
    reset    = 1'b1;
    ia.start = 1'b0;
    ib.start = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      mem_a[i] = 7'h0;
      mem_b[i] = 7'h0;
    end
    test_reset();
    test_blank();
    test_pattern();
    test_ignored_start();
    test_reset_mid();
    test_full_canvas();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
